fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00003000, first fetch address after reset.
REQ-002 Parameter IMEM_WORDS, default 4096, instruction memory size in words; legal PC range [RESET_PC, RESET_PC+4*IMEM_WORDS-4].
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
REQ-005 stall  in  1  decode stage cannot accept; instruction held while 1.
REQ-006 redirect_valid  in  1  one-cycle branch/jump redirect request.
REQ-007 redirect_pc  in  32  redirect target.
REQ-008 imem_req  out  1  instruction memory request; held until imem_ack.
REQ-009 imem_addr  out  32  word address of request, equal to fetch_pc.
REQ-010 imem_ack  in  1  memory response valid; may assert in the same cycle as imem_req.
REQ-011 imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-012 out_valid  out  1  instruction register holds a deliverable entry.
REQ-013 out_pc  out  32  PC of held instruction.
REQ-014 out_instr  out  32  held instruction word.
REQ-015 out_exc  out  1  held entry is an address fault (out_instr = 0).
REQ-016 fetch_cnt  out  32  count of entries consumed by decode.

Function
REQ-017 States SHALL be FETCH, DRAIN, HOLD, HALT; imem_req = 1 in FETCH (legal fetch_pc) and DRAIN only.
REQ-018 Consume event SHALL be out_valid & ~stall & ~redirect_valid, evaluated at posedge.
REQ-019 FETCH, legal fetch_pc, imem_ack=1: load out_pc=fetch_pc, out_instr=imem_rdata, out_exc=0, fetch_pc+=4, go HOLD.
REQ-020 FETCH, legal fetch_pc, imem_ack=0: keep imem_req/imem_addr stable, stay FETCH.
REQ-021 FETCH, fetch_pc misaligned (bits[1:0]!=0) or outside legal range: no imem_req; load out_pc=fetch_pc, out_instr=0, out_exc=1, fetch_pc unchanged, go HOLD.
REQ-022 HOLD: out_valid=1; on consume with out_exc=0 go FETCH; with out_exc=1 go HALT; otherwise hold all out_* unchanged.
REQ-023 HALT: out_valid=0, no imem_req; leaves only on redirect.
REQ-024 Redirect in HOLD or HALT: fetch_pc<=redirect_pc, out_valid<=0, go FETCH; no consume, fetch_cnt unchanged.
REQ-025 Redirect in FETCH with imem_ack=1: discard imem_rdata, fetch_pc<=redirect_pc, stay FETCH.
REQ-026 Redirect in FETCH with imem_ack=0 and imem_req=1: fetch_pc<=redirect_pc, go DRAIN; imem_addr SHALL hold old address in DRAIN (separate drain address register).
REQ-027 DRAIN: on imem_ack discard data, go FETCH; a further redirect in DRAIN overwrites fetch_pc (latest wins).
REQ-028 Redirect has priority over stall and over consume in the same cycle.
REQ-029 fetch_pc+4 and fetch_cnt+1 SHALL wrap modulo 2^32.
REQ-030 fetch_cnt SHALL increment by 1 on each consume event, including faulted entries.
REQ-031 Minimum throughput one instruction per 2 cycles with zero-wait memory.

Reset
REQ-032 Reset SHALL take priority over redirect, ack and consume in the same cycle.
REQ-033 After reset: state FETCH, fetch_pc=RESET_PC, out_valid=0, out_pc=0, out_instr=0, out_exc=0, fetch_cnt=0; imem_req=0 during the reset cycle.
REQ-034 Reset in DRAIN SHALL abandon the outstanding request; a later stale imem_ack in FETCH is indistinguishable and SHALL be accepted as the fetch of RESET_PC.

Verification
REQ-035 Reset, zero-wait memory returning addr-derived words, stall=0 -> out_pc 0x3000, 0x3004, 0x3008 on every second cycle; fetch_cnt=3 after third consume.
REQ-036 stall=1 for 5 cycles while HOLD at 0x3004 -> out_valid, out_pc=0x3004, out_instr stable; no imem_req; fetch_cnt unchanged.
REQ-037 Memory with 3-cycle ack latency, redirect to 0x3100 one cycle after req at 0x3008 -> DRAIN holds imem_addr=0x3008 until ack; data discarded; next req at 0x3100; out_pc 0x3008 never delivered.
REQ-038 Redirect to 0x3002 -> no imem_req; out_valid=1, out_exc=1, out_instr=0, out_pc=0x3002; after consume HALT, out_valid=0; redirect to 0x3000 resumes fetch.
REQ-039 Redirect to 0x6FFC then consume -> fetch_pc 0x7000 faults with out_exc=1 (range boundary).
REQ-040 reset asserted same cycle as imem_ack and redirect_valid -> REQ-033 reset values next cycle; fetch_cnt=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- instruction fetch controller with a single instruction register
//
// The controller fetches one word from instruction memory, holds it in the
// output register until decode consumes it, and then fetches the next word.
// A fetch address that is misaligned or outside the instruction memory is
// never sent to memory. Instead it becomes a faulted entry with out_exc=1.
// When decode consumes a faulted entry the controller halts until the next
// redirect arrives.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   stall                 decode cannot accept the held entry
//   redirect_valid/_pc    one-cycle branch/jump redirect request
//   imem_req/_addr        memory request, held stable until imem_ack
//   imem_ack/_rdata       memory response (may arrive in the request cycle)
//   out_valid/_pc/_instr  held entry presented to decode
//   out_exc               held entry is an address fault (out_instr = 0)
//   fetch_cnt             number of entries consumed by decode (wraps)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter int          IMEM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        out_exc,
   output logic [31:0] fetch_cnt
);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   // Last legal word address. The sum is formed in 33 bits so that a memory
   // ending exactly at 2^32 does not wrap the bound to a small value.
   localparam logic [32:0] PC_FIRST = {1'b0, RESET_PC};
   localparam logic [32:0] PC_LAST  = PC_FIRST + (33'(IMEM_WORDS) * 33'd4) - 33'd4;

   logic [1:0]  state_reg,      state_next;
   logic [31:0] fetch_pc_reg,   fetch_pc_next;
   logic [31:0] drain_addr_reg, drain_addr_next;
   logic [31:0] out_pc_reg,     out_pc_next;
   logic [31:0] out_instr_reg,  out_instr_next;
   logic        out_exc_reg,    out_exc_next;
   logic [31:0] fetch_cnt_reg,  fetch_cnt_next;

   logic pc_legal;
   logic consume;

   assign pc_legal = (fetch_pc_reg[1:0] == 2'b00) &&
                     ({1'b0, fetch_pc_reg} >= PC_FIRST) &&
                     ({1'b0, fetch_pc_reg} <= PC_LAST);

   // The held entry is deliverable only in HOLD. A redirect clears it by
   // leaving HOLD, so the out_* registers keep their last contents.
   assign out_valid = (state_reg == ST_HOLD);
   assign consume   = out_valid & ~stall & ~redirect_valid;

   // DRAIN keeps presenting the abandoned address until its ack arrives.
   // The new target waits in fetch_pc_reg meanwhile.
   assign imem_req  = ~reset & (((state_reg == ST_FETCH) & pc_legal) | (state_reg == ST_DRAIN));
   assign imem_addr = (state_reg == ST_DRAIN) ? drain_addr_reg : fetch_pc_reg;

   assign out_pc    = out_pc_reg;
   assign out_instr = out_instr_reg;
   assign out_exc   = out_exc_reg;
   assign fetch_cnt = fetch_cnt_reg;

   always_comb begin
      state_next      = state_reg;
      fetch_pc_next   = fetch_pc_reg;
      drain_addr_next = drain_addr_reg;
      out_pc_next     = out_pc_reg;
      out_instr_next  = out_instr_reg;
      out_exc_next    = out_exc_reg;
      fetch_cnt_next  = fetch_cnt_reg;

      case (state_reg)
         ST_FETCH: begin
            if (pc_legal) begin
               if (redirect_valid) begin
                  fetch_pc_next = redirect_pc;
                  if (!imem_ack) begin
                     // The request is still in flight, so its ack must be absorbed.
                     drain_addr_next = fetch_pc_reg;
                     state_next      = ST_DRAIN;
                  end
               end else if (imem_ack) begin
                  out_pc_next    = fetch_pc_reg;
                  out_instr_next = imem_rdata;
                  out_exc_next   = 1'b0;
                  fetch_pc_next  = fetch_pc_reg + 32'd4;
                  state_next     = ST_HOLD;
               end
            end else begin
               if (redirect_valid) begin
                  fetch_pc_next = redirect_pc;
               end else begin
                  // fetch_pc stays on the faulting address.
                  out_pc_next    = fetch_pc_reg;
                  out_instr_next = 32'd0;
                  out_exc_next   = 1'b1;
                  state_next     = ST_HOLD;
               end
            end
         end
         ST_DRAIN: begin
            if (redirect_valid) begin
               fetch_pc_next = redirect_pc;
            end
            if (imem_ack) begin
               state_next = ST_FETCH;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               fetch_pc_next = redirect_pc;
               state_next    = ST_FETCH;
            end else if (consume) begin
               fetch_cnt_next = fetch_cnt_reg + 32'd1;
               state_next     = out_exc_reg ? ST_HALT : ST_FETCH;
            end
         end
         default: begin // ST_HALT
            if (redirect_valid) begin
               fetch_pc_next = redirect_pc;
               state_next    = ST_FETCH;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_FETCH;
         fetch_pc_reg   <= RESET_PC;
         drain_addr_reg <= 32'd0;
         out_pc_reg     <= 32'd0;
         out_instr_reg  <= 32'd0;
         out_exc_reg    <= 1'b0;
         fetch_cnt_reg  <= 32'd0;
      end else begin
         state_reg      <= state_next;
         fetch_pc_reg   <= fetch_pc_next;
         drain_addr_reg <= drain_addr_next;
         out_pc_reg     <= out_pc_next;
         out_instr_reg  <= out_instr_next;
         out_exc_reg    <= out_exc_next;
         fetch_cnt_reg  <= fetch_cnt_next;
      end
   end

endmodule
